// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and Gray-code helpers for the asynchronous FIFO.
//   FIFO_ADDRSIZE      : default memory address width
//   FIFO_DEPTH         : default number of entries (2**FIFO_ADDRSIZE)
//   FIFO_AFULL_THRESH  : default almost-full occupancy threshold
//   bin2gray/gray2bin  : 32-bit reference conversions; callers truncate
//                        to their pointer width
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDRSIZE     = 8;
    localparam int FIFO_DEPTH        = 1 << FIFO_ADDRSIZE;
    localparam int FIFO_AFULL_THRESH = FIFO_DEPTH - 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
//   Combinational Gray-to-binary converter. Each binary bit is the XOR of
//   all Gray bits at or above its position (prefix XOR from the MSB).
//   Ports:
//     gray : in  WIDTH  Gray-coded value
//     bin  : out WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
//   Write-domain pointer and status generator for the asynchronous FIFO.
//   Advances a Gray write pointer on accepted writes, drives the memory write
//   address/strobe, and derives full, almost-full, level and sticky overflow
//   from the read pointer already synchronized into wclk.
//   Ports:
//     wclk         : in  1           write-domain clock
//     wrst_n       : in  1           asynchronous active-low reset
//     winc         : in  1           write request from producer
//     wq2_rptr     : in  ADDRSIZE+1  synchronized Gray read pointer
//     wovf_clr     : in  1           clears the sticky overflow flag
//     wptr         : out ADDRSIZE+1  registered Gray write pointer
//     waddr        : out ADDRSIZE    binary memory write address
//     wen          : out 1           memory write strobe (combinational)
//     wfull        : out 1           FIFO full (registered)
//     walmost_full : out 1           occupancy >= AFULL_THRESH (registered)
//     wlevel       : out ADDRSIZE+1  pessimistic occupancy (registered)
//     wovf         : out 1           sticky: write attempted while full
//
//   Handshake: winc acts as valid and ~wfull as ready. A write is accepted
//   (wen = 1, pointer advances) only on an edge where winc = 1 and wfull = 0;
//   winc while full is dropped and sets wovf instead.
// -----------------------------------------------------------------------------
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    // Threshold narrowed to pointer width; its legal range fits in ADDRSIZE+1 bits.
    localparam logic [31:0]       AFULL_32 = AFULL_THRESH;
    localparam logic [ADDRSIZE:0] AFULL_T  = AFULL_32[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbnext;
    logic [ADDRSIZE:0] wgnext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvl_next;
    logic              full_next;

    fifo_gray2bin #(
        .WIDTH (ADDRSIZE + 1)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    assign wen    = winc & ~wfull;
    assign waddr  = wbin[ADDRSIZE-1:0];
    assign wbnext = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgnext = (wbnext >> 1) ^ wbnext;

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the two MSBs differ and the rest match.
    assign full_next = (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                    wq2_rptr[ADDRSIZE-2:0]});

    // Modulo subtraction; the read pointer lags, so this never under-reports.
    assign lvl_next = wbnext - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbnext;
            wptr         <= wgnext;
            wfull        <= full_next;
            wlevel       <= lvl_next;
            walmost_full <= (lvl_next >= AFULL_T);
            // A dropped write sets the flag even if a clear arrives with it.
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full
//   Self-checking bench for fifo_wptr_full (ADDRSIZE = 8). The reference
//   model tracks total writes and reads as plain integers; occupancy, full,
//   almost-full and the expected Gray pointer are derived from those counts.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full;

    localparam int AW     = 8;
    localparam int DEPTH  = 1 << AW;
    localparam int THRESH = DEPTH - 4;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic          wovf_clr;
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic          wen;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          wovf;

    fifo_wptr_full #(
        .ADDRSIZE     (AW),
        .AFULL_THRESH (THRESH)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    // ---------------- clock / reset ----------------
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // ---------------- reference model state ----------------
    int unsigned wr_cnt;     // total accepted writes since reset
    int unsigned rd_cnt;     // reads visible in wclk domain (drives wq2_rptr)
    bit          m_full;
    bit          m_ovf;
    int unsigned m_level;

    int n_checks;
    int n_fail;

    function automatic logic [AW:0] to_gray(input int unsigned n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".wptr"},  32'(wptr),  32'(to_gray(wr_cnt)));
        check_eq({ctx, ".waddr"}, 32'(waddr), wr_cnt % DEPTH);
        check_eq({ctx, ".wfull"}, 32'(wfull), 32'(m_full));
        check_eq({ctx, ".wlevel"}, 32'(wlevel), m_level);
        check_eq({ctx, ".afull"}, 32'(walmost_full), 32'(m_level >= THRESH));
        check_eq({ctx, ".wovf"},  32'(wovf),  32'(m_ovf));
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        @(negedge wclk);
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wovf_clr = 1'b0;
        rd_cnt   = 0;
        wq2_rptr = '0;
        wr_cnt   = 0;
        m_full   = 0;
        m_ovf    = 0;
        m_level  = 0;
        #1;
        check_outputs("reset");
        check_eq("reset.wen", 32'(wen), 32'd1);
        @(negedge wclk);
        check_outputs("reset_hold");
        wrst_n = 1'b1;
        winc   = 1'b0;
    endtask

    // One write-clock cycle: drive at negedge, check wen, update model at the
    // rising edge, then check registered outputs just after it.
    task automatic step(input bit inc, input bit clr, input string ctx);
        bit accept;
        @(negedge wclk);
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = to_gray(rd_cnt);
        accept   = inc && !m_full;
        #1;
        check_eq({ctx, ".wen"}, 32'(wen), 32'(accept));
        @(posedge wclk);
        if (accept) wr_cnt++;
        if (inc && m_full) m_ovf = 1;
        else if (clr)      m_ovf = 0;
        m_level = wr_cnt - rd_cnt;
        m_full  = (m_level == DEPTH);
        #1;
        check_outputs(ctx);
    endtask

    // ---------------- test sequence ----------------
    logic [AW:0] prev_wptr;
    bit          seen_wrap;
    bit          saw_full;
    int unsigned max_lvl;
    int unsigned hist[$];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        wrst_n    = 1'b0;
        winc      = 1'b0;
        wovf_clr  = 1'b0;
        wq2_rptr  = '0;

        // Reset with winc held high, then the first write.
        do_reset();
        step(1, 0, "first");
        check_eq("first.waddr1", 32'(waddr), 32'd1);
        check_eq("first.wptr1",  32'(wptr),  32'h001);

        // Fill to full with the read pointer parked at zero.
        for (int i = 2; i <= DEPTH; i++) begin
            step(1, 0, "fill");
            if (i == THRESH - 1) check_eq("fill.afull_before", 32'(walmost_full), 32'd0);
            if (i == THRESH)     check_eq("fill.afull_at",     32'(walmost_full), 32'd1);
            if (i == DEPTH - 1)  check_eq("fill.not_full_255", 32'(wfull), 32'd0);
        end
        check_eq("fill.wptr180", 32'(wptr),   32'h180);
        check_eq("fill.level256", 32'(wlevel), 32'd256);
        check_eq("fill.full",    32'(wfull),  32'd1);

        // Overflow: dropped writes, then clear racing with a dropped write.
        for (int i = 0; i < 3; i++) step(1, 0, "ovf");
        check_eq("ovf.wptr_hold", 32'(wptr), 32'h180);
        check_eq("ovf.set", 32'(wovf), 32'd1);
        step(1, 1, "ovf_clr_race");
        check_eq("ovf.race_keeps", 32'(wovf), 32'd1);
        step(0, 1, "ovf_clr");
        check_eq("ovf.cleared", 32'(wovf), 32'd0);

        // Release by one read, then refill with a single write.
        rd_cnt = 1;
        step(0, 0, "release");
        check_eq("release.full0", 32'(wfull),  32'd0);
        check_eq("release.lvl255", 32'(wlevel), 32'd255);
        step(1, 0, "refill");
        check_eq("refill.full1", 32'(wfull), 32'd1);

        // Read advance coinciding with a write attempt while full.
        rd_cnt++;
        step(1, 0, "rd_and_wr_full");
        check_eq("rd_and_wr_full.full0", 32'(wfull), 32'd0);

        // Random traffic around the full boundary.
        for (int i = 0; i < 400; i++) begin
            if (rd_cnt < wr_cnt && $urandom_range(0, 1) == 1) rd_cnt++;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, "rand");
        end

        // Wrap: read pointer tracks the write pointer two cycles behind.
        do_reset();
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
        seen_wrap = 0;
        saw_full  = 0;
        max_lvl   = 0;
        prev_wptr = wptr;
        for (int i = 0; i < 600; i++) begin
            rd_cnt = hist[$-1];
            step(1, 0, "wrap");
            hist.push_back(wr_cnt);
            if (hist.size() > 4) void'(hist.pop_front());
            if (prev_wptr == 9'h100 && wptr == 9'h000) seen_wrap = 1;
            if (wfull) saw_full = 1;
            if (32'(wlevel) > max_lvl) max_lvl = 32'(wlevel);
            prev_wptr = wptr;
        end
        check_eq("wrap.seen_100_to_0", 32'(seen_wrap), 32'd1);
        check_eq("wrap.never_full",    32'(saw_full),  32'd0);
        check_eq("wrap.level_le3",     32'(max_lvl <= 3), 32'd1);

        // Mid-operation reset clears state without a clock edge.
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 0, "pre_rst");
        check_eq("pre_rst.wptr", 32'(wptr), 32'(to_gray(100)));
        #2;
        wrst_n = 1'b0;
        #1;
        check_eq("async_rst.wptr",   32'(wptr),   32'd0);
        check_eq("async_rst.waddr",  32'(waddr),  32'd0);
        check_eq("async_rst.wlevel", 32'(wlevel), 32'd0);
        check_eq("async_rst.wovf",   32'(wovf),   32'd0);
        check_eq("async_rst.wfull",  32'(wfull),  32'd0);
        check_eq("async_rst.afull",  32'(walmost_full), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
